// File: rtl/mcu_pkg.sv
// mcu_pkg -- shared types and constants for the multicycle control unit.
//   state_t        : FSM state encoding (also exported on the debug port)
//   instr_class_t  : instruction class produced by mcu_decode
//   OP_*           : opcode values (zero-extended to 32 bits for comparison)
//   ALU_*          : 4-bit ALU operation codes driven in EXEC
package mcu_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        CLS_RTYPE,
        CLS_STORE,
        CLS_LOAD,
        CLS_IMM,
        CLS_BRANCH,
        CLS_JUMP,
        CLS_JAL,
        CLS_JR,
        CLS_ILLEGAL
    } instr_class_t;

    localparam logic [31:0] OP_RTYPE = 32'h0;
    localparam logic [31:0] OP_SW    = 32'h1;
    localparam logic [31:0] OP_LW    = 32'h2;
    localparam logic [31:0] OP_ADDI  = 32'h3;
    localparam logic [31:0] OP_ANDI  = 32'h4;
    localparam logic [31:0] OP_ORI   = 32'h5;
    localparam logic [31:0] OP_BEQ   = 32'h6;
    localparam logic [31:0] OP_BNE   = 32'h7;
    localparam logic [31:0] OP_BGE   = 32'h8;
    localparam logic [31:0] OP_BGT   = 32'h9;
    localparam logic [31:0] OP_BLE   = 32'hA;
    localparam logic [31:0] OP_BLT   = 32'hB;
    localparam logic [31:0] OP_J     = 32'hC;
    localparam logic [31:0] OP_JAL   = 32'hD;
    localparam logic [31:0] OP_JR    = 32'hE;

    localparam logic [3:0] ALU_NONE = 4'b0000;
    localparam logic [3:0] ALU_R    = 4'b0010;
    localparam logic [3:0] ALU_AND  = 4'b0011;
    localparam logic [3:0] ALU_OR   = 4'b0100;
    localparam logic [3:0] ALU_BEQ  = 4'b0101;
    localparam logic [3:0] ALU_BNE  = 4'b0110;
    localparam logic [3:0] ALU_BGE  = 4'b0111;
    localparam logic [3:0] ALU_BGT  = 4'b1000;
    localparam logic [3:0] ALU_BLE  = 4'b1001;
    localparam logic [3:0] ALU_BLT  = 4'b1010;

endpackage

// File: rtl/mcu_decode.sv
// mcu_decode -- purely combinational opcode decoder.
//   opcode   in  OPCODE_W  latched opcode
//   cls      out           instruction class
//   alu_code out  4        ALU operation code used in EXEC
//   legal    out  1        opcode is one of the defined instructions
module mcu_decode
    import mcu_pkg::*;
#(
    parameter int OPCODE_W = 6
) (
    input  logic [OPCODE_W-1:0] opcode,
    output instr_class_t        cls,
    output logic [3:0]          alu_code,
    output logic                legal
);

    logic [31:0] op_ext;

    // NOTE: every combinational output gets a default first, so no path
    // through the case statement can leave a value held (no latch).
    always_comb begin
        op_ext                 = '0;
        op_ext[OPCODE_W-1:0]   = opcode;
        cls                    = CLS_ILLEGAL;
        alu_code               = ALU_NONE;
        case (op_ext)
            OP_RTYPE: begin cls = CLS_RTYPE;  alu_code = ALU_R;   end
            OP_SW:          cls = CLS_STORE;
            OP_LW:          cls = CLS_LOAD;
            OP_ADDI:        cls = CLS_IMM;
            OP_ANDI:  begin cls = CLS_IMM;    alu_code = ALU_AND; end
            OP_ORI:   begin cls = CLS_IMM;    alu_code = ALU_OR;  end
            OP_BEQ:   begin cls = CLS_BRANCH; alu_code = ALU_BEQ; end
            OP_BNE:   begin cls = CLS_BRANCH; alu_code = ALU_BNE; end
            OP_BGE:   begin cls = CLS_BRANCH; alu_code = ALU_BGE; end
            OP_BGT:   begin cls = CLS_BRANCH; alu_code = ALU_BGT; end
            OP_BLE:   begin cls = CLS_BRANCH; alu_code = ALU_BLE; end
            OP_BLT:   begin cls = CLS_BRANCH; alu_code = ALU_BLT; end
            OP_J:           cls = CLS_JUMP;
            OP_JAL:         cls = CLS_JAL;
            OP_JR:          cls = CLS_JR;
            default:        cls = CLS_ILLEGAL;
        endcase
        legal = (cls != CLS_ILLEGAL);
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit -- FSM sequencing a multicycle datapath.
// Optional feature: define ILLEGAL_OP_TRAP_EN to send undefined opcodes to
// TRAP (illegal_op held until trap_ack); otherwise they execute as a NOP.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   instr                 instruction register contents (opcode sampled in DECODE)
//   mem_ready             memory transfer complete (FETCH / MEM only)
//   trap_ack              trap acknowledge (TRAP only)
//   ir_write, pc_write    IR load, unconditional PC update
//   iord                  memory address select (0 = PC, 1 = ALU result)
//   branch, jump          conditional PC update, jump target select
//   mem_read, mem_write   memory strobes
//   mem_to_reg, pc_to_reg write-back source selects
//   alusrc, reg_write     immediate operand, register file write
//   reg_dest              write destination select
//   aluop                 ALU operation (zero-extended, 0 outside EXEC)
//   illegal_op            trap pending
//   state                 current state, for debug
module multicycle_control_unit
    import mcu_pkg::*;
#(
    parameter int INSTR_W    = 32,
    parameter int OPCODE_W   = 6,
    parameter int OPCODE_LSB = 26,
    parameter int ALUOP_W    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INSTR_W-1:0] instr,
    input  logic               mem_ready,
    input  logic               trap_ack,
    output logic               ir_write,
    output logic               pc_write,
    output logic               iord,
    output logic               branch,
    output logic [1:0]         jump,
    output logic               mem_read,
    output logic               mem_write,
    output logic               mem_to_reg,
    output logic               pc_to_reg,
    output logic               alusrc,
    output logic               reg_write,
    output logic [1:0]         reg_dest,
    output logic [ALUOP_W-1:0] aluop,
    output logic               illegal_op,
    output logic [2:0]         state
);

    state_t              state_q;
    logic [OPCODE_W-1:0] opcode_q;
    // Set on the first edge after reset release so IDLE lasts one full
    // cycle and the first FETCH lands on the second rising edge.
    logic                run_q;

    instr_class_t cls;
    logic [3:0]   alu_code;
    logic         legal;

    // Only the opcode field of instr is consumed here; trap_ack is only
    // consumed when the trap feature is built in.
    logic unused_inputs;
    assign unused_inputs = ^{instr, trap_ack};

    mcu_decode #(.OPCODE_W(OPCODE_W)) u_decode (
        .opcode   (opcode_q),
        .cls      (cls),
        .alu_code (alu_code),
        .legal    (legal)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            opcode_q <= '0;
            run_q    <= 1'b0;
        end else begin
            run_q <= 1'b1;
            case (state_q)
                S_IDLE:   if (run_q) state_q <= S_FETCH;
                S_FETCH:  if (mem_ready) state_q <= S_DECODE;
                S_DECODE: begin
                    opcode_q <= instr[OPCODE_LSB +: OPCODE_W];
                    state_q  <= S_EXEC;
                end
                S_EXEC: begin
                    if (!legal) begin
`ifdef ILLEGAL_OP_TRAP_EN
                        state_q <= S_TRAP;
`else
                        state_q <= S_FETCH;
`endif
                    end else begin
                        case (cls)
                            CLS_RTYPE, CLS_IMM:  state_q <= S_WB;
                            CLS_LOAD, CLS_STORE: state_q <= S_MEM;
                            default:             state_q <= S_FETCH;
                        endcase
                    end
                end
                S_MEM: begin
                    if (mem_ready)
                        state_q <= (cls == CLS_LOAD) ? S_WB : S_FETCH;
                end
                S_WB: state_q <= S_FETCH;
                S_TRAP: begin
`ifdef ILLEGAL_OP_TRAP_EN
                    if (trap_ack) state_q <= S_FETCH;
`else
                    state_q <= S_FETCH;
`endif
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Outputs decode the registered state and opcode; the only input that
    // reaches an output is mem_ready, which qualifies the FETCH-complete
    // strobes in the cycle the memory returns the instruction.
    always_comb begin
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        iord       = 1'b0;
        branch     = 1'b0;
        jump       = 2'b00;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        pc_to_reg  = 1'b0;
        alusrc     = 1'b0;
        reg_write  = 1'b0;
        reg_dest   = 2'b00;
        aluop      = '0;
        illegal_op = 1'b0;
        state      = state_q;
        case (state_q)
            S_FETCH: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                end
            end
            S_EXEC: begin
                aluop[3:0] = alu_code;
                case (cls)
                    CLS_STORE, CLS_LOAD, CLS_IMM: alusrc = 1'b1;
                    CLS_BRANCH: branch = 1'b1;
                    CLS_JUMP: begin
                        alusrc   = 1'b1;
                        pc_write = 1'b1;
                        jump     = 2'b01;
                    end
                    CLS_JAL: begin
                        alusrc    = 1'b1;
                        pc_write  = 1'b1;
                        jump      = 2'b01;
                        reg_write = 1'b1;
                        pc_to_reg = 1'b1;
                        reg_dest  = 2'b10;
                    end
                    CLS_JR: begin
                        alusrc   = 1'b1;
                        pc_write = 1'b1;
                        jump     = 2'b10;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                iord      = 1'b1;
                mem_read  = (cls == CLS_LOAD);
                mem_write = (cls == CLS_STORE);
            end
            S_WB: begin
                reg_write  = 1'b1;
                reg_dest   = (cls == CLS_RTYPE) ? 2'b01 : 2'b00;
                mem_to_reg = (cls == CLS_LOAD);
            end
            S_TRAP: begin
`ifdef ILLEGAL_OP_TRAP_EN
                illegal_op = 1'b1;
`endif
            end
            default: ;
        endcase
    end

endmodule
